// File: rtl/calculadora_sincrona_param.sv
// Parametrised accumulator calculator: ALU ops, shift-add multiplier, operand stack,
// status flags and a valid/ready command handshake.
module calculadora_sincrona_param #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] entrada,
   input  logic [3:0]       codigo,
   input  logic             valid_in,
   output logic             ready,
   output logic [WIDTH-1:0] saida,
   output logic             valid_out,
   output logic             busy,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             erro
);
   localparam int OW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_LOAD = 4'b0000, OP_ADD = 4'b0001, OP_SUB  = 4'b0010,
                          OP_READ = 4'b0011, OP_AND = 4'b0100, OP_OR   = 4'b0101,
                          OP_XOR  = 4'b0110, OP_MUL = 4'b0111, OP_PUSH = 4'b1000,
                          OP_POP  = 4'b1001, OP_CLR = 4'b1010;

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n, saida_n;
   logic [WIDTH-1:0] mcand, mcand_n, mplier, mplier_n, prod, prod_n;
   logic             z_n, c_n, v_n, vo_n, erro_n, push_en;
   logic [OW-1:0]    occ, occ_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] stack [DEPTH];
   logic [WIDTH:0]   sum, dif;
   logic [WIDTH-1:0] step;
   logic [AW-1:0]    wr_idx, top_idx;
   logic             full, empty;

   assign busy    = (state == MUL);
   assign ready   = !busy;
   assign sum     = {1'b0, acc} + {1'b0, entrada};
   // Extended subtraction: the top bit is the unsigned borrow.
   assign dif     = {1'b0, acc} - {1'b0, entrada};
   assign full    = (occ == OW'(DEPTH));
   assign empty   = (occ == '0);
   assign wr_idx  = AW'(occ);
   assign top_idx = AW'(occ - 1'b1);
   assign step    = mplier[0] ? mcand : '0;

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      z_n      = flag_z;
      c_n      = flag_c;
      v_n      = flag_v;
      saida_n  = saida;
      vo_n     = 1'b0;
      erro_n   = 1'b0;
      occ_n    = occ;
      push_en  = 1'b0;
      cnt_n    = cnt;
      mcand_n  = mcand;
      mplier_n = mplier;
      prod_n   = prod;
      case (state)
         IDLE: if (valid_in) begin
            case (codigo)
               OP_LOAD: begin acc_n = entrada;       c_n = 1'b0; v_n = 1'b0; end
               OP_ADD: begin
                  acc_n = sum[WIDTH-1:0];
                  c_n   = sum[WIDTH];
                  v_n   = (acc[WIDTH-1] == entrada[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
               end
               OP_SUB: begin
                  acc_n = dif[WIDTH-1:0];
                  c_n   = dif[WIDTH];
                  v_n   = (acc[WIDTH-1] != entrada[WIDTH-1]) && (dif[WIDTH-1] != acc[WIDTH-1]);
               end
               OP_READ: begin saida_n = acc; vo_n = 1'b1; end
               OP_AND:  begin acc_n = acc & entrada; c_n = 1'b0; v_n = 1'b0; end
               OP_OR:   begin acc_n = acc | entrada; c_n = 1'b0; v_n = 1'b0; end
               OP_XOR:  begin acc_n = acc ^ entrada; c_n = 1'b0; v_n = 1'b0; end
               OP_MUL: begin
                  mcand_n = acc;
                  mplier_n = entrada;
                  prod_n  = '0;
                  cnt_n   = '0;
                  state_n = MUL;
               end
               OP_PUSH: begin
                  if (full) erro_n = 1'b1;
                  else begin push_en = 1'b1; occ_n = occ + 1'b1; end
               end
               OP_POP: begin
                  if (empty) erro_n = 1'b1;
                  else begin
                     acc_n = stack[top_idx];
                     occ_n = occ - 1'b1;
                     c_n   = 1'b0;
                     v_n   = 1'b0;
                  end
               end
               OP_CLR:  begin acc_n = '0; occ_n = '0; c_n = 1'b0; v_n = 1'b0; end
               default: erro_n = 1'b1;
            endcase
            // Z only follows real accumulator writes, so READ/PUSH/errors keep it.
            if (!erro_n && codigo != OP_READ && codigo != OP_PUSH && codigo != OP_MUL)
               z_n = (acc_n == '0);
         end
         MUL: begin
            prod_n   = prod + step;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            if (cnt == CW'(WIDTH-1)) begin
               acc_n   = prod_n;
               z_n     = (prod_n == '0);
               c_n     = 1'b0;
               v_n     = 1'b0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
         saida     <= '0;
         valid_out <= 1'b0;
         erro      <= 1'b0;
         occ       <= '0;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         flag_z    <= z_n;
         flag_c    <= c_n;
         flag_v    <= v_n;
         saida     <= saida_n;
         valid_out <= vo_n;
         erro      <= erro_n;
         occ       <= occ_n;
         cnt       <= cnt_n;
         mcand     <= mcand_n;
         mplier    <= mplier_n;
         prod      <= prod_n;
      end
   end

   // Stack contents beyond occupancy are don't-care, so no reset.
   always_ff @(posedge clk) begin
      if (push_en) stack[wr_idx] <= acc;
   end

endmodule

// File: tb/tb_calculadora_sincrona_param.sv
// Scoreboard bench for calculadora_sincrona_param: arithmetic reference model,
// READ results and error pulses are checked by an independent monitor.
module tb_calculadora_sincrona_param;
   localparam int W    = 8;
   localparam int D    = 4;
   localparam int MOD  = 1 << W;
   localparam int MAXS = MOD/2 - 1;
   localparam int MINS = -(MOD/2);

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] entrada;
   logic [3:0]   codigo;
   logic         valid_in;
   logic         ready, valid_out, busy, flag_z, flag_c, flag_v, erro;
   logic [W-1:0] saida;

   calculadora_sincrona_param #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .entrada(entrada), .codigo(codigo), .valid_in(valid_in),
      .ready(ready), .saida(saida), .valid_out(valid_out), .busy(busy),
      .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .erro(erro)
   );

   always #5 clk = ~clk;

   typedef struct { int s; bit z; bit c; bit v; } rd_t;

   int  checks = 0, errors = 0;
   int  err_exp = 0, err_seen = 0;
   rd_t rdq[$];
   int  m_acc;
   bit  m_z, m_c, m_v;
   int  m_stk[$];

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int sx(input int x);
      return (x >= MOD/2) ? x - MOD : x;
   endfunction

   task automatic wr(input int a, input bit c, input bit v);
      m_acc = a; m_z = (a == 0); m_c = c; m_v = v;
   endtask

   task automatic model_reset();
      m_acc = 0; m_z = 0; m_c = 0; m_v = 0;
      m_stk.delete();
   endtask

   task automatic model(input int op, input int e);
      int r, s;
      case (op)
         0:  wr(e, 0, 0);
         1:  begin r = m_acc + e; s = sx(m_acc) + sx(e);
                   wr(r % MOD, r >= MOD, s > MAXS || s < MINS); end
         2:  begin r = m_acc - e; s = sx(m_acc) - sx(e);
                   wr((r + MOD) % MOD, m_acc < e, s > MAXS || s < MINS); end
         3:  rdq.push_back('{m_acc, m_z, m_c, m_v});
         4:  wr(m_acc & e, 0, 0);
         5:  wr(m_acc | e, 0, 0);
         6:  wr(m_acc ^ e, 0, 0);
         7:  wr(int'((longint'(m_acc) * longint'(e)) % MOD), 0, 0);
         8:  if (m_stk.size() == D) err_exp++; else m_stk.push_back(m_acc);
         9:  if (m_stk.size() == 0) err_exp++; else wr(m_stk.pop_back(), 0, 0);
         10: begin m_stk.delete(); wr(0, 0, 0); end
         default: err_exp++;
      endcase
   endtask

   // Called on a negative edge; returns on the negative edge after acceptance.
   task automatic cmd(input int op, input int e);
      int n = 0;
      while (!ready && n < 200) begin @(negedge clk); n++; end
      check("ready_before_cmd", ready, 1);
      codigo = 4'(op); entrada = W'(e); valid_in = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0;
      model(op, e);
      @(negedge clk);
   endtask

   task automatic mul_busy(input int e);
      int n = 0;
      cmd(7, e);
      while (busy && n < 100) begin
         n++;
         codigo = 4'($urandom_range(0, 10)); entrada = W'($urandom); valid_in = 1'b1;
         @(negedge clk);
      end
      valid_in = 1'b0;
      check("mul_busy_cycles", n, W);
   endtask

   task automatic chk_reset_vals();
      check("rst_saida", saida, 0);
      check("rst_valid_out", valid_out, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 1);
      check("rst_flags", {flag_z, flag_c, flag_v}, 0);
      check("rst_erro", erro, 0);
   endtask

   always @(negedge clk) begin
      rd_t r;
      if (!rst) begin
         if (valid_out) begin
            if (rdq.size() == 0) check("unexpected_valid_out", valid_out, 0);
            else begin
               r = rdq.pop_front();
               check("saida", saida, r.s);
               check("flag_z", flag_z, r.z);
               check("flag_c", flag_c, r.c);
               check("flag_v", flag_v, r.v);
            end
         end
         if (erro) err_seen++;
      end
   end

   initial begin
      rst = 1'b1; valid_in = 1'b0; codigo = '0; entrada = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      @(negedge clk);

      cmd(3, 0);
      cmd(0, 8'hF0); cmd(1, 8'h20); cmd(3, 0);
      cmd(0, 8'h7F); cmd(1, 8'h01); cmd(3, 0);
      cmd(0, 8'h05); cmd(2, 8'h05); cmd(3, 0);
      cmd(2, 8'h01); cmd(3, 0);
      cmd(0, 12); mul_busy(13); cmd(3, 0);
      cmd(0, 8'h20); mul_busy(8'h10); cmd(3, 0);
      for (int i = 1; i <= 4; i++) begin cmd(0, i); cmd(8, 0); end
      cmd(0, 8'hAA); cmd(8, 0); cmd(3, 0);
      for (int i = 0; i < 5; i++) begin cmd(9, 0); cmd(3, 0); end
      cmd(4'b1100, 8'h33); cmd(3, 0);

      // Reset in the middle of a multiply must leave no trace.
      cmd(0, 12); cmd(7, 13);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      #1 chk_reset_vals();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cmd(3, 0);
      cmd(0, 3); mul_busy(5); cmd(3, 0);

      for (int i = 0; i < 400; i++) begin
         int op;
         op = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
         cmd(op, $urandom_range(0, MOD-1));
         if ($urandom_range(0, 3) == 0) cmd(3, 0);
      end
      cmd(3, 0);

      repeat (3) @(negedge clk);
      check("erro_count", err_seen, err_exp);
      check("reads_pending", rdq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/calculadora_sincrona_param.md
# calculadora_sincrona_param

Parametrised synchronous accumulator calculator, successor to the 8-bit four-operation calculator. Adds configurable data width, logic ops, a multi-cycle shift-add multiplier, status flags, a hardware operand stack of configurable depth and a valid/ready command handshake. Sits between the switch/keypad command front-end and the display driver; the display latches `saida` on `valid_out`.

## Interface
- `WIDTH`, 8, datapath, accumulator and stack-entry width (≥2)
- `DEPTH`, 4, stack entries (≥1); occupancy counter is `$clog2(DEPTH+1)` bits
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `entrada`  in  WIDTH  operand
- `codigo`  in  4  operation code
- `valid_in`  in  1  command present this cycle
- `ready`  out  1  command can be accepted; equals `!busy`
- `saida`  out  WIDTH  registered result of last READ
- `valid_out`  out  1  one-cycle pulse when `saida` is updated
- `busy`  out  1  multiply in progress
- `flag_z`, `flag_c`, `flag_v`  out  1 each  zero, carry/borrow, signed overflow of accumulator
- `erro`  out  1  one-cycle pulse on rejected command

## Operation
- Command accepted on a rising edge with `valid_in && ready`; ignored otherwise (no queueing, no error).
- Codes (acc = accumulator, e = `entrada`):
  - 0000 LOAD: acc ← e
  - 0001 ADD: acc ← acc+e; C = carry out of bit WIDTH-1; V = signed overflow
  - 0010 SUB: acc ← acc−e; C = borrow (acc<e unsigned); V = signed overflow
  - 0011 READ: `saida` ← acc, `valid_out` pulses; acc and flags unchanged
  - 0100 AND, 0101 OR, 0110 XOR: acc ← acc op e
  - 0111 MUL: acc ← low WIDTH bits of acc×e (unsigned), multi-cycle
  - 1000 PUSH: stack[top] ← acc; occupancy+1
  - 1001 POP: acc ← stack top; occupancy−1
  - 1010 CLEAR: acc ← 0, stack emptied
  - 1011–1111: illegal
- Flags: Z recomputed on every acc write (Z=1 iff acc==0). C and V set only by ADD/SUB; every other acc write (LOAD, logic, MUL, POP, CLEAR) clears C and V. READ and PUSH leave all flags unchanged.
- Errors (`erro` pulses, acc/stack/flags unchanged): PUSH when occupancy==DEPTH; POP when occupancy==0; illegal code.
- Stack is LIFO; PUSH-then-POP returns the same value; contents beyond occupancy are don't-care.
- States: IDLE, MUL. MUL latches multiplicand and multiplier at acceptance, performs one shift-add step per cycle for WIDTH cycles, then writes acc and returns to IDLE.
- `saida` holds its value between READs (not zeroed by other ops).

## Timing
- Reset: acc=0, occupancy=0, `saida`=0, `valid_out`=0, `busy`=0, `ready`=1, all flags 0, `erro`=0, state IDLE. Reset during MUL aborts it; no partial result reaches acc.
- Single-cycle ops: result in acc/flags visible the cycle after the accepting edge; READ: `saida`/`valid_out` visible the cycle after the accepting edge.
- `erro` asserted the cycle after the accepting edge, for exactly one cycle.
- MUL accepted at edge T: `busy`=1 from T to T+WIDTH; acc, Z, C=0, V=0 updated at edge T+WIDTH, same edge `busy` drops; next command accepted at T+WIDTH+1 at the earliest.
- `valid_in` while `busy`: dropped, `ready`=0 tells the sender.
- All arithmetic modulo 2^WIDTH.

## Test plan
- Reset then READ (WIDTH=8) -> `saida`=0x00, `valid_out` one pulse, Z=0 (flags untouched by READ after reset).
- LOAD 0xF0, ADD 0x20, READ -> `saida`=0x10, C=1, V=0, Z=0; LOAD 0x7F, ADD 0x01 -> acc 0x80, C=0, V=1.
- LOAD 0x05, SUB 0x05 -> acc 0, Z=1, C=0; SUB 0x01 -> acc 0xFF, C=1, Z=0.
- LOAD 12, MUL 13 -> `busy` high 8 cycles, commands during busy ignored, then READ gives 156 (0x9C); LOAD 0x20, MUL 0x10 -> 0x00, Z=1.
- DEPTH=4: PUSH 1,2,3,4 (loading between), fifth PUSH -> `erro` pulse; four POPs return 4,3,2,1; fifth POP -> `erro`, acc stays 1.
- Illegal code 1100 -> `erro` one pulse, state unchanged; assert `rst` mid-MUL -> all outputs at reset values, next MUL runs normally.
